// File: rtl/bus_demux_1_4_pkg.sv
// Shared constants for the MIPS bus steering blocks: channel count, widths
// and the memory-mapped target indices.
package mips_bus_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [SEL_W-1:0] {
    CH_DMEM = 2'd0,
    CH_IO   = 2'd1,
    CH_TMR  = 2'd2,
    CH_DBG  = 2'd3
  } ch_e;

endpackage

// File: rtl/bus_demux_1_4_if.sv
// Handshake bundle for the 1:4 write demux: one upstream valid/ready port
// and four downstream valid/ready channels with packed payloads.
interface bus_demux_1_4_if
  import mips_bus_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);

  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        in_sel;
  logic [WIDTH-1:0]        in_data;
  logic [NUM_CH-1:0]       out_valid;
  logic [NUM_CH-1:0]       out_ready;
  logic [NUM_CH*WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/bus_demux_1_4_slot.sv
// One-entry registered channel buffer; a fill wins over a drain in the same cycle.
// BUS_DEMUX_CNT_EN adds a wrapping per-channel drain counter.
module demux_slot
  import mips_bus_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fill,
  input  logic [WIDTH-1:0] fill_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
`ifdef BUS_DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);

  logic drain;

  assign drain = out_valid & out_ready;

  // Payload is only written on fill, so it stays put after a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (fill) begin
      out_valid <= 1'b1;
      out_data  <= fill_data;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

`ifdef BUS_DEMUX_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (drain) begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/bus_demux_1_4.sv
// 1:4 handshake write demux steering upstream transactions to one of four
// buffered channels. BUS_DEMUX_CNT_EN adds per-channel drain counters on cnt.
module bus_demux_1_4
  import mips_bus_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bus_demux_1_4_if.slave          bus
`ifdef BUS_DEMUX_CNT_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] cnt
`endif
);

  logic              accept;
  logic [NUM_CH-1:0] fillVec;

  // Only the addressed channel gates acceptance, so a stalled target never
  // blocks writes to the others; out_ready passes through combinationally.
  assign bus.in_ready = ~bus.out_valid[bus.in_sel] | bus.out_ready[bus.in_sel];
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    fillVec              = '0;
    fillVec[bus.in_sel]  = accept;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : gSlot
    demux_slot #(
      .WIDTH(WIDTH)
    ) uSlot (
      .clk       (clk),
      .rst_n     (rst_n),
      .fill      (fillVec[i]),
      .fill_data (bus.in_data),
      .out_ready (bus.out_ready[i]),
      .out_valid (bus.out_valid[i]),
      .out_data  (bus.out_data[i*WIDTH +: WIDTH])
`ifdef BUS_DEMUX_CNT_EN
      ,
      .cnt       (cnt[i*CNT_W +: CNT_W])
`endif
    );
  end

endmodule
